// File: rtl/rv_register_file.sv
// RV32I integer register file: 32 x XLEN, two combinational read ports, one clocked write port, x0 reads zero.
// Optional `REGFILE_BYPASS_EN forwards the same-cycle write data to a matching read port.
module rv_register_file #(
  parameter int              XLEN      = 32,
  parameter int              NREGS     = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      i_r_reg_num_1,
  input  logic [4:0]      i_r_reg_num_2,
  input  logic [4:0]      i_w_reg_num,
  input  logic [XLEN-1:0] i_w_val,
  input  logic            op,
  output logic [XLEN-1:0] r_reg_1,
  output logic [XLEN-1:0] r_reg_2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  // x0 and out-of-range indices never hold architectural state.
  function automatic logic idx_live(input logic [4:0] idx);
    return (idx != 5'd0) && (32'(idx) < NREGS);
  endfunction

  assign wr_en = !rst && op && idx_live(i_w_reg_num);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
    end else if (wr_en) begin
      regs[i_w_reg_num] <= i_w_val;
    end
  end

  always_comb begin
    r_reg_1 = '0;
    r_reg_2 = '0;
    if (!rst) begin
      if (idx_live(i_r_reg_num_1)) r_reg_1 = regs[i_r_reg_num_1];
      if (idx_live(i_r_reg_num_2)) r_reg_2 = regs[i_r_reg_num_2];
`ifdef REGFILE_BYPASS_EN
      // wr_en already excludes x0 and reset, so forwarding never leaks into x0.
      if (wr_en && (i_r_reg_num_1 == i_w_reg_num)) r_reg_1 = i_w_val;
      if (wr_en && (i_r_reg_num_2 == i_w_reg_num)) r_reg_2 = i_w_val;
`endif
    end
  end

endmodule

// File: tb/tb_rv_register_file.sv
// Randomized bench for rv_register_file against an array-based architectural model.
module tb_rv_register_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  i_r_reg_num_1 = '0;
  logic [4:0]  i_r_reg_num_2 = '0;
  logic [4:0]  i_w_reg_num = '0;
  logic [31:0] i_w_val = '0;
  logic        op = 1'b0;
  logic [31:0] r_reg_1;
  logic [31:0] r_reg_2;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mdl [32];

  rv_register_file dut (
    .clk           (clk),
    .rst           (rst),
    .i_r_reg_num_1 (i_r_reg_num_1),
    .i_r_reg_num_2 (i_r_reg_num_2),
    .i_w_reg_num   (i_w_reg_num),
    .i_w_val       (i_w_val),
    .op            (op),
    .r_reg_1       (r_reg_1),
    .r_reg_2       (r_reg_2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (rst || idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (op && i_w_reg_num == idx) return i_w_val;
`endif
    return mdl[idx];
  endfunction

  // Apply one cycle: drive at negedge, check reads mid-cycle, then commit the model after posedge.
  task automatic step(input logic r, input logic o, input logic [4:0] w, input logic [31:0] v,
                      input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    rst = r; op = o; i_w_reg_num = w; i_w_val = v;
    i_r_reg_num_1 = a; i_r_reg_num_2 = b;
    #2;
    check("rd1", r_reg_1, model_read(a));
    check("rd2", r_reg_2, model_read(b));
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end else if (o && w != 5'd0) begin
      mdl[w] = v;
    end
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

    // reset, then every register reads zero on both ports
    step(1'b1, 1'b1, 5'd3, 32'h5555_5555, 5'd3, 5'd0);
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 1'b0, 5'(i), 32'hFFFF_FFFF, 5'(i), 5'(32 - i));
      check("rst_x", r_reg_1, 32'h0);
    end

    step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    check("x5_p1", r_reg_1, 32'hDEAD_BEEF);
    check("x5_p2", r_reg_2, 32'hDEAD_BEEF);

    step(1'b0, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check("x0_wr", r_reg_1, 32'h0);

    step(1'b0, 1'b0, 5'd7, 32'hFFFF_FFFF, 5'd7, 5'd7);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    check("op0_x7", r_reg_1, 32'h0);

    step(1'b0, 1'b1, 5'd9, 32'h11, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd9, 32'h22, 5'd9, 5'd9);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    check("x9_new", r_reg_1, 32'h22);

    step(1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    check("x3_set", r_reg_1, 32'hA5A5_A5A5);
    step(1'b1, 1'b1, 5'd3, 32'h1, 5'd3, 5'd3);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
    check("x3_rst", r_reg_1, 32'h0);

    // random traffic, with read indices biased toward the write index
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] w, a, b;
      w = 5'($urandom_range(0, 31));
      a = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), w,
           (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom), a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
